// File: rtl/sub16b_serial_pkg.sv
// Shared definitions for the slice-serial subtractor: FSM encoding and
// default geometry, also imported by the bench.
package sub16b_serial_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index counter width; never zero so a single-slice build still elaborates.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub16b_serial_slice.sv
// One SLICE-bit subtract step with borrow in/out; the SLICE+1-bit difference
// wraps negative results so its top bit is the borrow out.
module sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             b_in,
    output logic [SLICE-1:0] d,
    output logic             b_out
);

    logic [SLICE:0] diff;

    assign diff  = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, b_in};
    assign d     = diff[SLICE-1:0];
    assign b_out = diff[SLICE];

endmodule

// File: rtl/sub16b_serial.sv
// Sequential WIDTH-bit subtractor: one SLICE-bit slice per clock, LSB first,
// behind a start/done handshake. WIDTH must be a multiple of SLICE.
module sub16b_serial
    import sub16b_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_D,
    output logic             o_Bo,
    output logic             o_V
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_bits(NSLICE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, d_q, d_full;
    logic             borrow_q;
    logic [IDX_W-1:0] idx_q;
    logic [SLICE-1:0] a_sl, b_sl, d_sl;
    logic             b_out;
    logic             accept, last, v_next;

    assign accept = (state_q == ST_IDLE) && i_start;
    assign last   = (state_q == ST_RUN) && (idx_q == IDX_W'(NSLICE - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_start) state_d = ST_RUN;
            ST_RUN:  if (last)    state_d = ST_DONE;
            ST_DONE:              state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q != ST_IDLE);
        o_done = (state_q == ST_DONE);
    end

    // ---------------- slice datapath ----------------
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDX_W'(s)) begin
                a_sl = a_q[s*SLICE +: SLICE];
                b_sl = b_q[s*SLICE +: SLICE];
            end
        end
    end

    sub_slice #(.SLICE(SLICE)) u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .b_in  (borrow_q),
        .d     (d_sl),
        .b_out (b_out)
    );

    // Working result with the current slice merged in, so the last edge can
    // publish the complete difference without an extra cycle.
    always_comb begin
        d_full = d_q;
        for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDX_W'(s)) d_full[s*SLICE +: SLICE] = d_sl;
        end
    end

    assign v_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_full[WIDTH-1] != a_q[WIDTH-1]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            o_D      <= '0;
            o_Bo     <= 1'b0;
            o_V      <= 1'b0;
        end else if (accept) begin
            a_q      <= i_A;
            b_q      <= i_B;
            d_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
        end else if (state_q == ST_RUN) begin
            d_q      <= d_full;
            borrow_q <= b_out;
            idx_q    <= idx_q + 1'b1;
            if (last) begin
                o_D  <= d_full;
                o_Bo <= b_out;
                o_V  <= v_next;
            end
        end
    end

endmodule
